mem_copy_engine: RTL and testbench

- Block-copy / block-fill engine placed directly upstream of the data memory. It owns the memory's address, write-enable and write-data inputs.
- When idle, the CPU load/store path passes through to the memory unchanged.
- When started, it takes over the memory port, copies a byte range or fills it with a constant, then reports completion.
- The memory read is combinational (same-cycle data) and the write is sequential. The engine relies on both.

---
 rtl/mem_copy_pkg.sv | 25 ++
 rtl/mem_port_mux.sv | 31 +++
 rtl/mem_copy_engine.sv | 148 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_pkg
// Shared types and constants for the block-copy / block-fill engine that sits
// in front of the data memory.
//   copy_state_t : engine FSM states
//   ADDR_W       : memory address width (256-entry space)
//   DATA_W       : memory data width
//   LEN_W        : transfer length width, wide enough to hold MAX_LEN
//   MAX_LEN      : largest transfer, one full pass over the address space
// -----------------------------------------------------------------------------
package mem_copy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } copy_state_t;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 9;
    localparam int MAX_LEN = 256;

endpackage

// File: rtl/mem_port_mux.sv
// -----------------------------------------------------------------------------
// mem_port_mux
// Combinational owner select for the data-memory port.
//   eng_sel                         : 1 = engine drives the port, 0 = CPU
//   cpu_addr/cpu_write/cpu_data     : CPU load/store path
//   eng_addr/eng_write/eng_wdata    : engine drivers
//   mem_addr/mem_write/mem_wdata    : to the data memory
// -----------------------------------------------------------------------------
module mem_port_mux
    import mem_copy_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          eng_sel,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_write,
    input  logic [DW-1:0] cpu_data,
    input  logic [AW-1:0] eng_addr,
    input  logic          eng_write,
    input  logic [DW-1:0] eng_wdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata
);

    assign mem_addr  = eng_sel ? eng_addr  : cpu_addr;
    assign mem_write = eng_sel ? eng_write : cpu_write;
    assign mem_wdata = eng_sel ? eng_wdata : cpu_data;

endmodule

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Block-copy / block-fill engine placed directly upstream of the data memory.
// While idle the CPU path passes straight through; once started the engine
// takes the port, copies (read then write, one byte per pair of cycles) or
// fills (one byte per cycle) a forward byte range, then pulses done.
// The memory read is combinational and the write lands on the clock edge.
// Ports:
//   CLK, reset (async, active low)
//   start, fill_mode, src_addr, dst_addr, length, fill_val : command
//   cpu_addr, cpu_write, cpu_data                          : CPU access
//   mem_rdata                                              : memory read data
//   mem_addr, mem_write, mem_wdata                         : to the memory
//   busy      : engine owns the port (RD/WR)
//   done      : one-cycle completion pulse
//   cpu_stall : CPU write was dropped this cycle
// -----------------------------------------------------------------------------
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W,
    parameter int LW = LEN_W
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic          fill_mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] length,
    input  logic [DW-1:0] fill_val,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_write,
    input  logic [DW-1:0] cpu_data,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          cpu_stall
);

    localparam logic [LW-1:0] MAX_LEN_LW = LW'(MAX_LEN);

    copy_state_t   state_q, state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          mode_q, mode_d;

    logic [AW-1:0] eng_addr;
    logic          eng_write;
    logic          mux_write;

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;
        mode_d      = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d      = fill_mode;
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    remaining_d = (length > MAX_LEN_LW) ? MAX_LEN_LW : length;
                    // In fill mode the data buffer holds the fill constant, so
                    // the write path always sources buf_q.
                    buf_d       = fill_mode ? fill_val : buf_q;
                    if (length == '0)
                        state_d = DONE;
                    else
                        state_d = fill_mode ? WR : RD;
                end
            end
            RD: begin
                buf_d     = mem_rdata;
                src_ptr_d = src_ptr_q + AW'(1);
                state_d   = WR;
            end
            WR: begin
                dst_ptr_d   = dst_ptr_q + AW'(1);
                remaining_d = remaining_q - LW'(1);
                if (remaining_q == LW'(1))
                    state_d = DONE;
                else
                    state_d = mode_q ? WR : RD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            buf_q       <= buf_d;
            mode_q      <= mode_d;
        end
    end

    assign busy      = (state_q == RD) || (state_q == WR);
    assign done      = (state_q == DONE);
    assign cpu_stall = busy & cpu_write;

    assign eng_addr  = (state_q == RD) ? src_ptr_q : dst_ptr_q;
    assign eng_write = (state_q == WR);

    mem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .eng_sel   (busy),
        .cpu_addr  (cpu_addr),
        .cpu_write (cpu_write),
        .cpu_data  (cpu_data),
        .eng_addr  (eng_addr),
        .eng_write (eng_write),
        .eng_wdata (buf_q),
        .mem_addr  (mem_addr),
        .mem_write (mux_write),
        .mem_wdata (mem_wdata)
    );

    // Gate with reset so a write (engine or CPU) is withdrawn the instant
    // reset asserts, without waiting for a clock edge.
    assign mem_write = mux_write & reset;

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_WR   = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] addr;
        logic       fill;
        logic [7:0] fval;
    } cyc_t;

    logic       CLK;
    logic       reset;
    logic       start;
    logic       fill_mode;
    logic [7:0] src_addr, dst_addr, fill_val;
    logic [8:0] length;
    logic [7:0] cpu_addr, cpu_data;
    logic       cpu_write;
    logic [7:0] mem_rdata, mem_addr, mem_wdata;
    logic       mem_write, busy, done, cpu_stall;

    int n_asserts = 0;
    int n_fail    = 0;

    mem_copy_engine dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .fill_mode (fill_mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .fill_val  (fill_val),
        .cpu_addr  (cpu_addr),
        .cpu_write (cpu_write),
        .cpu_data  (cpu_data),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .cpu_stall (cpu_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory attached to the DUT: combinational read, clocked write.
    logic [7:0] bench_mem [0:255];
    always @(posedge CLK) if (mem_write) bench_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = bench_mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted command is expanded into the list of cycles it must
    // produce; memory contents are tracked as bytes actually land.
    logic [7:0] ref_mem [0:255];
    cyc_t       exp_q[$];
    cyc_t       cur;
    logic [7:0] last_rd;

    initial begin
        cyc_t e;
        int   n;
        cur     = '0;
        last_rd = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        forever begin
            @(posedge CLK or negedge reset);
            if (!reset) begin
                exp_q.delete();
                cur = '0;
            end else begin
                case (cur.kind)
                    K_IDLE, K_DONE: if (cpu_write) ref_mem[cpu_addr] = cpu_data;
                    K_RD:           last_rd = ref_mem[cur.addr];
                    default:        ref_mem[cur.addr] = cur.fill ? cur.fval : last_rd;
                endcase
                if (cur.kind == K_IDLE && start) begin
                    n = (length > 9'd256) ? 256 : int'(length);
                    for (int i = 0; i < n; i++) begin
                        if (!fill_mode) begin
                            e = '0; e.kind = K_RD; e.addr = src_addr + 8'(i);
                            exp_q.push_back(e);
                        end
                        e = '0; e.kind = K_WR; e.addr = dst_addr + 8'(i);
                        e.fill = fill_mode; e.fval = fill_val;
                        exp_q.push_back(e);
                    end
                    e = '0; e.kind = K_DONE;
                    exp_q.push_back(e);
                end
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                else                   cur = '0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        logic [7:0] ea, ew;
        logic       ewe, eb, ed, es;
        forever begin
            @(negedge CLK);
            ea = cpu_addr; ew = 8'h00; ewe = 1'b0; eb = 1'b0; ed = 1'b0; es = 1'b0;
            if (reset) begin
                case (cur.kind)
                    K_IDLE, K_DONE: begin
                        ewe = cpu_write; ew = cpu_data; ed = (cur.kind == K_DONE);
                    end
                    K_RD: begin
                        ea = cur.addr; eb = 1'b1; es = cpu_write;
                    end
                    default: begin
                        ea = cur.addr; ewe = 1'b1; eb = 1'b1; es = cpu_write;
                        ew = cur.fill ? cur.fval : last_rd;
                    end
                endcase
            end
            if (!ewe) ew = 8'h00;
            check("cycle_outputs",
                  {12'h0, mem_addr, (mem_write ? mem_wdata : 8'h00), mem_write, busy, done, cpu_stall},
                  {12'h0, ea, ew, ewe, eb, ed, es});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data = d; cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
    endtask

    task automatic start_op(input logic fm, input logic [7:0] s, input logic [7:0] d,
                            input logic [8:0] len, input logic [7:0] fv);
        fill_mode = fm; src_addr = s; dst_addr = d; length = len; fill_val = fv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic observe(input int ncyc, output int bc, output int da, output int dc,
                           output int wc, output int rc);
        bc = 0; da = 0; dc = 0; wc = 0; rc = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CLK);
            if (busy) begin
                bc++;
                if (mem_write) wc++; else rc++;
            end
            if (done) begin
                dc++;
                if (da == 0) da = c;
            end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int bc, da, dc, wc, rc, diff;
        reset = 1'b0; start = 1'b0; fill_mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_val = '0;
        cpu_addr = 8'h33; cpu_data = 8'h77; cpu_write = 1'b1;
        #1;
        check("reset_mem_write", {31'h0, mem_write}, 32'h0);
        check("reset_mem_addr", {24'h0, mem_addr}, 32'h33);
        check("reset_busy_done", {30'h0, busy, done}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        cpu_write = 1'b0;
        step();
        reset = 1'b1;
        step();

        cpu_wr(8'h10, 8'd1); cpu_wr(8'h11, 8'd2); cpu_wr(8'h12, 8'd3); cpu_wr(8'h13, 8'd4);
        cpu_wr(8'h20, 8'd7);

        // Copy 4 bytes 0x10 -> 0x40
        start_op(1'b0, 8'h10, 8'h40, 9'd4, 8'h00);
        observe(12, bc, da, dc, wc, rc);
        check("copy_busy_cycles", bc, 8);
        check("copy_done_cycle", da, 9);
        check("copy_done_pulses", dc, 1);
        check("copy_rd_wr", {rc[15:0], wc[15:0]}, {16'd4, 16'd4});
        check("copy_data", {bench_mem[8'h40], bench_mem[8'h41], bench_mem[8'h42], bench_mem[8'h43]},
              32'h01020304);

        // Fill 4 bytes at 0xFE with wrap
        start_op(1'b1, 8'h00, 8'hFE, 9'd4, 8'hA5);
        observe(8, bc, da, dc, wc, rc);
        check("fill_busy_cycles", bc, 4);
        check("fill_no_rd", rc, 0);
        check("fill_done_cycle", da, 5);
        check("fill_data", {bench_mem[8'hFE], bench_mem[8'hFF], bench_mem[8'h00], bench_mem[8'h01]},
              32'hA5A5A5A5);

        // Zero length
        start_op(1'b0, 8'h10, 8'h50, 9'd0, 8'h00);
        observe(4, bc, da, dc, wc, rc);
        check("zero_busy", bc, 0);
        check("zero_done_cycle", da, 1);
        check("zero_untouched", {24'h0, bench_mem[8'h50]}, 32'h0);

        // Overlapping forward copy replicates the first byte
        start_op(1'b0, 8'h20, 8'h21, 9'd3, 8'h00);
        observe(9, bc, da, dc, wc, rc);
        check("overlap_done_cycle", da, 7);
        check("overlap_data", {8'h0, bench_mem[8'h21], bench_mem[8'h22], bench_mem[8'h23]},
              32'h00070707);

        // CPU write while busy is dropped, lands after done; extra start ignored
        start_op(1'b0, 8'h10, 8'h80, 9'd4, 8'h00);
        cpu_addr = 8'h05; cpu_data = 8'h09; cpu_write = 1'b1;
        bc = 0; da = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (busy) bc++;
            if (done && da == 0) da = c;
            if (c == 1) check("stall_flag", {31'h0, cpu_stall}, 32'h1);
            if (c == 8) check("stall_dropped", {24'h0, bench_mem[8'h05]}, 32'h0);
            if (c == 10) check("stall_retry_lands", {24'h0, bench_mem[8'h05]}, 32'h09);
            if (c == 3) begin
                #1;
                fill_mode = 1'b1; dst_addr = 8'h90; length = 9'd2; fill_val = 8'hEE;
                start = 1'b1;
            end
            if (c == 4) begin #1; start = 1'b0; end
            if (c == 10) begin #1; cpu_write = 1'b0; end
        end
        check("busy_start_busy_cycles", bc, 8);
        check("busy_start_done_cycle", da, 9);
        check("busy_start_ignored", {24'h0, bench_mem[8'h90]}, 32'h0);
        check("busy_copy_data", {bench_mem[8'h80], bench_mem[8'h81], bench_mem[8'h82], bench_mem[8'h83]},
              32'h01020304);

        // Reset during the second write of a 4-byte fill
        step();
        start_op(1'b1, 8'h00, 8'h60, 9'd4, 8'h3C);
        step();
        #2;
        reset = 1'b0;
        #1;
        check("abort_mem_write_async", {31'h0, mem_write}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        observe(3, bc, da, dc, wc, rc);
        check("abort_no_done", dc, 0);
        step();
        reset = 1'b1;
        cpu_addr = 8'h07;
        #1;
        check("abort_passthrough", {24'h0, mem_addr}, 32'h07);
        check("abort_partial", {16'h0, bench_mem[8'h60], bench_mem[8'h61]}, 32'h3C00);
        start_op(1'b1, 8'h00, 8'h62, 9'd1, 8'h11);
        observe(4, bc, da, dc, wc, rc);
        check("post_abort_done_cycle", da, 2);
        check("post_abort_data", {24'h0, bench_mem[8'h62]}, 32'h11);

        // Length above 256 clamps to a full pass over the address space
        start_op(1'b1, 8'h00, 8'h00, 9'd300, 8'h5A);
        observe(260, bc, da, dc, wc, rc);
        check("clamp_busy_cycles", bc, 256);
        check("clamp_done_cycle", da, 257);
        diff = 0;
        for (int i = 0; i < 256; i++) if (bench_mem[i] !== 8'h5A) diff++;
        check("clamp_all_filled", diff, 0);
        diff = 0;
        for (int i = 0; i < 256; i++) if (bench_mem[i] !== ref_mem[i]) diff++;
        check("mem_vs_model", diff, 0);

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
